// File: rtl/conv1d_mac_sequencer.sv
// Sequenced 8-tap 1-D convolution controller: CFU command decode, ring/kernel buffers, one int8 MAC per clock.
// Optional macro CONV1D_SEQ_AUTO_ADVANCE_EN: advance start_filter_x by one column after every compute.
module conv1d_mac_sequencer #(
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int INT32_SIZE         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once raised, rsp_valid and rsp_payload hold until that transfer completes.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [6:0]            cmd,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [INT32_SIZE-1:0] rsp_payload,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int BUF_DEPTH = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int ADDR_W    = $clog2(BUF_DEPTH);
    localparam int FX_W      = $clog2(KERNEL_LENGTH);
    localparam int CH_W      = $clog2(MAX_INPUT_CHANNELS);
    localparam int DEPTH_W   = $clog2(MAX_INPUT_CHANNELS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [6:0] OP_WR_INPUT  = 7'd10;
    localparam logic [6:0] OP_WR_KERNEL = 7'd11;
    localparam logic [6:0] OP_RD_INPUT  = 7'd13;
    localparam logic [6:0] OP_RD_KERNEL = 7'd14;
    localparam logic [6:0] OP_SET_OFS   = 7'd20;
    localparam logic [6:0] OP_SET_DEPTH = 7'd26;
    localparam logic [6:0] OP_START     = 7'd41;
    localparam logic [6:0] OP_RD_ACC    = 7'd43;
    localparam logic [6:0] OP_SET_START = 7'd44;

    logic [1:0]                   state;
    logic signed [INT32_SIZE-1:0] acc;
    logic signed [INT32_SIZE-1:0] input_offset;
    logic [DEPTH_W-1:0]           input_depth;
    logic [FX_W-1:0]              start_filter_x;
    logic [FX_W-1:0]              drain_start;

    logic [7:0] input_buffer  [BUF_DEPTH];
    logic [7:0] kernel_buffer [BUF_DEPTH];

    logic [FX_W-1:0]   fx;
    logic [CH_W-1:0]   ch;
    logic              drain_cnt;
    logic              rd_valid;
    logic signed [7:0] k_q;
    logic signed [7:0] x_q;

    logic                         accept;
    logic                         addr_ok;
    logic [ADDR_W-1:0]            cmd_addr;
    logic                         ch_last;
    logic [FX_W-1:0]              col;
    logic [ADDR_W-1:0]            k_addr;
    logic [ADDR_W-1:0]            i_addr;
    logic signed [INT32_SIZE-1:0] k_ext;
    logic signed [INT32_SIZE-1:0] x_ext;
    logic signed [INT32_SIZE-1:0] product;

    function automatic logic [INT32_SIZE-1:0] sext8(input logic [7:0] b);
        return {{(INT32_SIZE-8){b[7]}}, b};
    endfunction

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign state_dbg = state;

    assign accept   = cmd_valid && cmd_ready;
    assign addr_ok  = (inp0 < INT32_SIZE'(BUF_DEPTH));
    assign cmd_addr = inp0[ADDR_W-1:0];

    // Ring rotation: filter tap fx reads input column (fx + start) mod KERNEL_LENGTH.
    assign col     = fx + start_filter_x;
    assign k_addr  = ADDR_W'(fx) * ADDR_W'(input_depth) + ADDR_W'(ch);
    assign i_addr  = ADDR_W'(col) * ADDR_W'(input_depth) + ADDR_W'(ch);
    assign ch_last = (DEPTH_W'(ch) + DEPTH_W'(1)) == input_depth;

    assign k_ext   = sext8(k_q);
    assign x_ext   = sext8(x_q);
    assign product = k_ext * (x_ext + input_offset);

`ifdef CONV1D_SEQ_AUTO_ADVANCE_EN
    assign drain_start = start_filter_x + FX_W'(1);
`else
    assign drain_start = start_filter_x;
`endif

    // Storage and the registered read stage; buffers are only written while idle.
    always_ff @(posedge clk) begin
        if (accept && addr_ok && (cmd == OP_WR_INPUT))
            input_buffer[cmd_addr] <= inp1[7:0];
        if (accept && addr_ok && (cmd == OP_WR_KERNEL))
            kernel_buffer[cmd_addr] <= inp1[7:0];
        k_q <= kernel_buffer[k_addr];
        x_q <= input_buffer[i_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            input_offset   <= '0;
            input_depth    <= '0;
            start_filter_x <= '0;
            rsp_payload    <= '0;
            fx             <= '0;
            ch             <= '0;
            drain_cnt      <= 1'b0;
            rd_valid       <= 1'b0;
        end else begin
            rd_valid <= (state == RUN);
            if (rd_valid)
                acc <= acc + product;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_payload <= '0;
                        state       <= RESP;
                        case (cmd)
                            OP_RD_INPUT:
                                if (addr_ok) rsp_payload <= sext8(input_buffer[cmd_addr]);
                            OP_RD_KERNEL:
                                if (addr_ok) rsp_payload <= sext8(kernel_buffer[cmd_addr]);
                            OP_SET_OFS:
                                input_offset <= inp1;
                            OP_SET_DEPTH: begin
                                if (inp1[INT32_SIZE-1])
                                    input_depth <= '0;
                                else if (inp1 > INT32_SIZE'(MAX_INPUT_CHANNELS))
                                    input_depth <= DEPTH_W'(MAX_INPUT_CHANNELS);
                                else
                                    input_depth <= inp1[DEPTH_W-1:0];
                            end
                            OP_START: begin
                                acc <= '0;
                                fx  <= '0;
                                ch  <= '0;
                                if (input_depth != '0)
                                    state <= RUN;
                            end
                            OP_RD_ACC:
                                rsp_payload <= acc;
                            OP_SET_START:
                                start_filter_x <= inp1[FX_W-1:0];
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (ch_last) begin
                        ch <= '0;
                        fx <= fx + FX_W'(1);
                        if (fx == FX_W'(KERNEL_LENGTH - 1)) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                DRAIN: begin
                    // The final MAC lands at the end of the first drain cycle, so acc is complete here.
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        rsp_payload    <= acc;
                        start_filter_x <= drain_start;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv1d_mac_sequencer.md
# conv1d_mac_sequencer

Multi-cycle controller for the 8-tap 1-D convolution datapath of the CFU. It replaces the single-cycle nested-loop accumulate with a sequenced pipeline performing one int8 MAC per clock. The block owns the input ring buffer and kernel buffer, accepts CFU commands over a valid/ready handshake, and returns one response per command. It sits directly between the CPU's CFU bus and the convolution storage.

## Interface
Parameters:
- `KERNEL_LENGTH`, 8: taps per filter; ring-buffer depth in columns. Must be a power of 2.
- `MAX_INPUT_CHANNELS`, 128: maximum value of `input_depth`.
- `INT32_SIZE`, 32: command operand and accumulator width.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: command accepted when high together with `cmd_valid`.
- `cmd`, input, 7: opcode.
- `inp0`, input, 32: address operand.
- `inp1`, input, 32: value operand.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: response consumed when high together with `rsp_valid`.
- `rsp_payload`, output, 32: response data.
- `busy`, output, 1: high while in RUN or DRAIN.

## Operation
Opcodes (all others are a no-op with response 0):
- 10: write `input_buffer[inp0] <= inp1[7:0]`.
- 11: write `kernel_buffer[inp0] <= inp1[7:0]`.
- 13: read input buffer; response is the sign-extended byte.
- 14: read kernel buffer; response is the sign-extended byte.
- 20: set `input_offset <= inp1` (signed 32-bit).
- 26: set `input_depth <= min(inp1, MAX_INPUT_CHANNELS)`. Negative values are treated as 0.
- 41: start compute.
- 43: response is `acc`.
- 44: set `start_filter_x <= inp1 mod KERNEL_LENGTH`.

Addressing:
- Addresses at or above `KERNEL_LENGTH*MAX_INPUT_CHANNELS` are invalid.
- Writes to an invalid address are dropped.
- Reads from an invalid address return 0.
- Every non-41 opcode still returns a response.

Compute:
- `acc` is cleared to 0 on entry.
- Iterate `fx` over 0..7 (outer) and `ch` over 0..depth-1 (inner).
- Each step adds `kernel[fx*depth+ch] * (input[((fx+start_filter_x) mod 8)*depth+ch] + input_offset)` to `acc`.
- Products are signed 32-bit; accumulation wraps modulo 2^32 with no saturation.
- The response payload is the final `acc`.

State machine:
- IDLE: on accepting opcode 41 with depth>0, go to RUN. On opcode 41 with depth=0, `acc=0` and go to RESP. On any other opcode, execute it and go to RESP.
- RUN: issue one buffer-read pair per cycle with registered reads. After the last index (fx=7, ch=depth-1) has been issued, go to DRAIN.
- DRAIN: retire the last 2 pipeline stages (read, MAC), then go to RESP.
- RESP: assert `rsp_valid`; `rsp_payload` and `rsp_valid` are held stable until `rsp_ready`, then go to IDLE.

Handshake and reset:
- `cmd_ready` = (state==IDLE). Exactly one command is in flight; there is no command queue.
- `rst` aborts any state and returns to IDLE.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_payload`=0, `busy`=0, `acc`=0, `input_offset`=0, `input_depth`=0, `start_filter_x`=0.
- Buffer contents are not reset.

## Timing
- Non-compute command accepted in cycle N: `rsp_valid` rises in N+1. For reads, payload is valid in N+1.
- Compute with depth D>0 accepted in cycle N: RUN occupies 8·D cycles and DRAIN 2 cycles; `rsp_valid` rises in N+8·D+3.
- Compute with D=0: `rsp_valid` rises in N+1.
- `rsp_ready` held low: the block stays in RESP indefinitely, `cmd_ready`=0, and no state changes.
- Write followed by a read of the same address in the next accepted command returns the new value (no hazard, because commands are serialised).
- Buffers and parameters are written only in IDLE, so they cannot change during RUN.

## Configuration
- `CONV1D_SEQ_AUTO_ADVANCE_EN` defined:
  - On leaving DRAIN, `start_filter_x <= (start_filter_x+1) mod 8`, advancing the ring by one column per output.
  - Opcode 44 still overrides.
- Undefined: `start_filter_x` changes only via opcode 44 or `rst`.

## Test plan
- Reset, then opcode 43 → response 0. Opcode 13 with `inp0`=5000 → response 0. Opcode 10 with `inp0`=5000 → no buffer change.
- depth=1, offset=0, start=0, kernel[0..7]=1, input[0..7]=0..7 → opcode 41 response 28, `rsp_valid` exactly 11 cycles after accept.
- depth=2, offset=128, all kernel=−1, all input=−128 → response 0. Then offset=−128 → response 4096 (16·(−1)·(−256)).
- depth=1, kernel[0]=1 and others 0, input[k]=k, start=3 → response 3. With `CONV1D_SEQ_AUTO_ADVANCE_EN`, three back-to-back computes give 3, 4, 5.
- Compute with depth=128, `rsp_ready` held low for 20 cycles after `rsp_valid` → payload stable and `cmd_ready`=0 throughout. Release → IDLE next cycle.
- Assert `rst` 100 cycles into a depth=128 compute → `busy`=0, `rsp_valid`=0, `cmd_ready`=1 immediately. A following opcode 43 returns 0.
